smm_mac_pipe: RTL

SMM_MAC_PIPE -- requirements
Module: smm_mac_pipe

---
 rtl/smm_mac_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/smm_mac_pipe.sv
// Pipelined multiply-accumulate: NUM_STAGE-1 product registers feeding a
// saturating accumulator register that drives dout.
module smm_mac_pipe #(
  parameter int unsigned DIN0_WIDTH = 32,
  parameter int unsigned DIN1_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  ovf
);

  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam int unsigned PDEPTH = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam logic [ACC_WIDTH-1:0] SAT_MAX =
    IS_SIGNED ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN =
    IS_SIGNED ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  if (ACC_WIDTH < DIN0_WIDTH + DIN1_WIDTH || NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_param
    $error("smm_mac_pipe: illegal parameter combination");
  end

  // Operands extended to ACC_WIDTH; the low ACC_WIDTH product bits are the exact extended product.
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] prod;

  assign a_ext = {{(ACC_WIDTH-DIN0_WIDTH){IS_SIGNED & din0[DIN0_WIDTH-1]}}, din0};
  assign b_ext = {{(ACC_WIDTH-DIN1_WIDTH){IS_SIGNED & din1[DIN1_WIDTH-1]}}, din1};
  assign prod  = a_ext * b_ext;

  logic [ACC_WIDTH-1:0] fin_prod;
  logic                 fin_vld;
  logic                 fin_en;
  logic                 fin_clr;

  if (NUM_STAGE > 1) begin : g_pipe
    logic [ACC_WIDTH-1:0] prod_q [PDEPTH];
    logic [PDEPTH-1:0]    vld_q;
    logic [PDEPTH-1:0]    en_q;
    logic [PDEPTH-1:0]    clr_q;

    // Control bits are qualified by in_valid on entry so bubbles carry no stale commands.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < int'(PDEPTH); i++) prod_q[i] <= '0;
        vld_q <= '0;
        en_q  <= '0;
        clr_q <= '0;
      end else if (ce) begin
        prod_q[0] <= prod;
        vld_q[0]  <= in_valid;
        en_q[0]   <= in_valid & acc_en;
        clr_q[0]  <= in_valid & acc_clr;
        for (int i = 1; i < int'(PDEPTH); i++) begin
          prod_q[i] <= prod_q[i-1];
          vld_q[i]  <= vld_q[i-1];
          en_q[i]   <= en_q[i-1];
          clr_q[i]  <= clr_q[i-1];
        end
      end
    end

    assign fin_prod = prod_q[PDEPTH-1];
    assign fin_vld  = vld_q[PDEPTH-1];
    assign fin_en   = en_q[PDEPTH-1];
    assign fin_clr  = clr_q[PDEPTH-1];
  end else begin : g_nopipe
    assign fin_prod = prod;
    assign fin_vld  = in_valid;
    assign fin_en   = in_valid & acc_en;
    assign fin_clr  = in_valid & acc_clr;
  end

  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                 ovf_q, ovf_d;
  logic                 ovld_q, ovld_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 clamp_hi;
  logic                 clamp_lo;

  // Final stage: load, saturating accumulate, or hold on a bubble.
  always_comb begin
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    ovld_d   = fin_vld;
    sum      = '0;
    clamp_hi = 1'b0;
    clamp_lo = 1'b0;
    if (IS_SIGNED) begin
      sum      = {dout_q[ACC_WIDTH-1], dout_q} + {fin_prod[ACC_WIDTH-1], fin_prod};
      clamp_hi = ~sum[ACC_WIDTH] & sum[ACC_WIDTH-1];
      clamp_lo = sum[ACC_WIDTH] & ~sum[ACC_WIDTH-1];
    end else begin
      sum      = {1'b0, dout_q} + {1'b0, fin_prod};
      clamp_hi = sum[ACC_WIDTH];
    end
    if (fin_vld) begin
      if (!fin_en || fin_clr) begin
        dout_d = fin_prod;
        ovf_d  = 1'b0;
      end else if (clamp_hi) begin
        dout_d = SAT_MAX;
        ovf_d  = 1'b1;
      end else if (clamp_lo) begin
        dout_d = SAT_MIN;
        ovf_d  = 1'b1;
      end else begin
        dout_d = sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
      ovld_q <= 1'b0;
    end else if (ce) begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      ovld_q <= ovld_d;
    end
  end

  // A held result is reported only on an enabled cycle, so it is consumed exactly once.
  assign out_valid = ovld_q & ce;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule
